// File: rtl/uart_tx_framed_if.sv
// Valid/ready word handshake into the framed UART transmitter.
// The source drives the master side; the transmitter is the slave.
interface uart_tx_framed_if #(
  parameter int DATA_BITS = 8
);
  logic [DATA_BITS-1:0] in_data;
  logic                 in_valid;
  logic                 in_ready;

  modport master (output in_data, output in_valid, input in_ready);
  modport slave  (input in_data, input in_valid, output in_ready);
endinterface

// File: rtl/uart_tx_framed.sv
// Framed UART transmitter: small input FIFO feeding a start/data/parity/stop serialiser
// whose bit timer restarts at every state entry, so frames chain with no idle gap.
module uart_tx_framed #(
  parameter int CLK_HZ     = 100_000_000,
  parameter int BAUD       = 9600,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                              clk,
  input  logic                              rst,
  uart_tx_framed_if.slave                   bus,
  output logic                              txd,
  output logic                              busy,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_count
);

  localparam int DIV = (CLK_HZ + BAUD / 2) / BAUD;
  localparam int TW  = $clog2(DIV);
  localparam int PW  = $clog2(FIFO_DEPTH);
  localparam int CW  = $clog2(FIFO_DEPTH + 1);
  localparam int BW  = $clog2(DATA_BITS + 1);

  if (DIV < 2 || DATA_BITS < 5 || DATA_BITS > 9 || PARITY < 0 || PARITY > 2 ||
      STOP_BITS < 1 || STOP_BITS > 2 || FIFO_DEPTH < 2 ||
      (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_param_check
    $error("uart_tx_framed: illegal parameter combination");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t                 state, state_next;
  logic [DATA_BITS-1:0]   mem [FIFO_DEPTH];
  logic [PW-1:0]          wr_ptr, rd_ptr;
  logic [TW-1:0]          timer;
  logic [BW-1:0]          bit_cnt;
  logic [DATA_BITS-1:0]   shifter, shifter_next;
  logic                   parity_bit;
  logic                   line_next;
  logic                   push, pop, bit_end, fifo_nonempty;

  // Parity over the word as loaded; odd parity is the inverted XOR.
  function automatic logic parity_of(input logic [DATA_BITS-1:0] word);
    return (^word) ^ (PARITY == 2);
  endfunction

  assign bus.in_ready  = (fifo_count != CW'(FIFO_DEPTH));
  assign push          = bus.in_valid && bus.in_ready;
  assign fifo_nonempty = (fifo_count != '0);
  assign bit_end       = (timer == TW'(DIV - 1));

  always_comb begin
    state_next = state;
    pop        = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (fifo_nonempty) begin
          state_next = S_START;
          pop        = 1'b1;
        end
      end
      S_START: begin
        if (bit_end) state_next = S_DATA;
      end
      S_DATA: begin
        if (bit_end && bit_cnt == BW'(DATA_BITS - 1))
          state_next = (PARITY != 0) ? S_PARITY : S_STOP;
      end
      S_PARITY: begin
        if (bit_end) state_next = S_STOP;
      end
      S_STOP: begin
        if (bit_end && bit_cnt == BW'(STOP_BITS - 1)) begin
          if (fifo_nonempty) begin
            state_next = S_START;
            pop        = 1'b1;
          end else begin
            state_next = S_IDLE;
          end
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  // txd is registered, so the line level is chosen from the state being entered.
  always_comb begin
    shifter_next = shifter;
    if (pop)
      shifter_next = mem[rd_ptr];
    else if (state == S_DATA && bit_end)
      shifter_next = shifter >> 1;

    line_next = 1'b1;
    case (state_next)
      S_START:  line_next = 1'b0;
      S_DATA:   line_next = shifter_next[0];
      S_PARITY: line_next = parity_bit;
      default:  line_next = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      timer      <= '0;
      bit_cnt    <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      txd        <= 1'b1;
      busy       <= 1'b0;
    end else begin
      state   <= state_next;
      timer   <= (state == S_IDLE || state_next != state || bit_end) ? '0 : timer + 1'b1;
      bit_cnt <= (state_next != state) ? '0 : (bit_end ? bit_cnt + 1'b1 : bit_cnt);
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
      txd  <= line_next;
      busy <= (state_next != S_IDLE);
    end
  end

  // Storage and shift data carry no reset; the control state decides what is valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= bus.in_data;
    shifter <= shifter_next;
    if (pop) parity_bit <= parity_of(mem[rd_ptr]);
  end

endmodule

// File: doc/uart_tx_framed.md
# uart_tx_framed

Parametrised UART transmitter for the board-level serial path: accepts words over a valid/ready handshake into a small internal FIFO and serialises them with configurable data width, parity and stop bits. It contains its own bit-time counter, which restarts at every frame boundary. Back-to-back frames go out with no idle gap. It replaces the fixed 8-N-1 transmitter plus separate free-running baud tick in the switch-to-UART demo top and in later designs.

## Interface
Parameters:
- CLK_HZ, 100_000_000, input clock frequency in Hz
- BAUD, 9600, line rate; DIV = (CLK_HZ + BAUD/2) / BAUD clocks per bit, must be >= 2
- DATA_BITS, 8, data bits per frame, legal 5..9
- PARITY, 0, 0 = none, 1 = even, 2 = odd
- STOP_BITS, 1, legal 1 or 2
- FIFO_DEPTH, 4, input FIFO entries, power of two, >= 2

Ports:
- clk  in  1  system clock; all logic on posedge
- rst  in  1  reset, synchronous, active-high
- in_data  in  DATA_BITS  word to transmit
- in_valid  in  1  in_data valid
- in_ready  out  1  FIFO can accept; equals (fifo_count != FIFO_DEPTH)
- txd  out  1  serial line, idle high, registered
- busy  out  1  high while a frame is on the line, registered
- fifo_count  out  $clog2(FIFO_DEPTH+1)  words waiting (not including the frame in flight)

## Operation
- Push: on an edge with in_valid && in_ready, in_data is written at the write pointer and fifo_count increments.
- Pop: on an edge where the FSM leaves IDLE or STOP with fifo_count != 0, the head is loaded into the shifter and fifo_count decrements.
- A simultaneous push and pop leaves fifo_count unchanged. Pointers wrap modulo FIFO_DEPTH.
- FSM states:
  - IDLE: txd = 1, busy = 0.
  - START: txd = 0.
  - DATA: txd = shifter[0], LSB first; the shifter shifts right once per bit.
  - PARITY: only when PARITY != 0.
  - STOP: txd = 1, for STOP_BITS bit times.
- Transitions:
  - IDLE -> START when fifo_count != 0.
  - START -> DATA after one bit time.
  - DATA -> PARITY (or STOP if PARITY == 0) after DATA_BITS bit times.
  - PARITY -> STOP after one bit time.
  - At the end of the last stop bit: -> START if fifo_count != 0, else -> IDLE.
- Parity bit: even = XOR of the DATA_BITS data bits; odd = inverse of that XOR. It is computed from the word as loaded, not from the shifted register.
- Bit timer: counts 0..DIV-1. It is reset to 0 on every state entry, so every line bit lasts exactly DIV clocks. There is no free-running tick and no phase carry-over.
- Frame length: DIV * (1 + DATA_BITS + (PARITY != 0) + STOP_BITS) clocks.
- Illegal parameter values trigger an elaboration-time error. No runtime checking.

## Timing
- Reset takes effect at the first posedge with rst = 1:
  - txd = 1, busy = 0, fifo_count = 0, pointers = 0, FSM = IDLE, timer = 0.
  - in_ready = 1 from the following cycle.
  - A frame in flight is aborted; txd returns high on that same edge.
  - FIFO contents are discarded.
- Latency from an empty, idle block: word pushed at edge E0 -> fifo_count = 1 after E0 -> pop, txd = 0 and busy = 1 at edge E0+1.
- Start-bit edge: txd and busy change on the same edge as the pop.
- Back-to-back frames: the last stop bit lasts exactly DIV clocks, then txd falls on the next edge. There is no extra idle cycle. busy stays 1 across the frame boundary.
- End of transmission: busy falls on the same edge txd would start the next bit, i.e. at the end of the last stop bit when the FIFO is empty.
- Full FIFO: in_ready = 0. in_valid is ignored and data is not captured. A pop on the same edge does not allow a same-edge push; in_ready rises on the next cycle.
- Empty FIFO with a push on the last stop-bit edge: the word is not seen that edge. The FSM enters IDLE for one cycle, then starts the frame.
- in_data/in_valid are sampled only on push edges. in_valid may stay high across multiple pushes; each accepted edge stores one word.

## Test plan
- 8-N-1, CLK_HZ = 1_000_000, BAUD = 100_000 (DIV = 10). Push 0xA5 -> txd low 10 clocks, then 1,0,1,0,0,1,0,1 at 10 clocks each, then high 10 clocks. busy high exactly 100 clocks. txd falls one edge after the push.
- DATA_BITS = 7, PARITY = 1 (even), STOP_BITS = 2. Push 0x07 -> data bits 1,1,1,0,0,0,0, parity 1, two stop bits. busy high 110 clocks. Repeat with PARITY = 2 -> parity 0.
- DATA_BITS = 9, PARITY = 0. Push 0x1FF then 0x000 -> second start bit begins exactly 110 clocks after the first. No idle gap. busy never drops between frames.
- FIFO_DEPTH = 4. Hold in_valid high for 6 cycles with values 1..6 while idle:
  - Word 1 is popped immediately; words 2..5 are stored; fifo_count reaches 4; in_ready = 0; word 6 is not accepted.
  - Frames 1..5 go out in order; in_ready rises the cycle after word 2 is popped.
- Assert rst for 1 cycle mid-way through data bit 3 with 2 words queued -> next edge txd = 1, busy = 0, fifo_count = 0. No further frames. The next push transmits normally.
- Push on the final stop-bit edge of the last queued frame -> exactly one idle cycle with txd = 1 and busy = 0, then the start bit.
